// File: rtl/fsm_step_arbiter_if.sv
// Requester-side bundle of the step arbiter: request/length/abort in, grant/step/result out.
// The shared sequencer's Moore output (seq_out) also travels in this bundle.
interface fsm_step_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int CNT_W = 4
);
  logic [NREQ-1:0]       req;
  logic [NREQ*CNT_W-1:0] len;
  logic                  abort;
  logic                  seq_out;
  logic                  step;
  logic [NREQ-1:0]       grant;
  logic                  busy;
  logic [NREQ-1:0]       done;
  logic [CNT_W-1:0]      hit_cnt;
  logic                  aborted;

  modport master (
    output req, len, abort, seq_out,
    input  step, grant, busy, done, hit_cnt, aborted
  );

  modport slave (
    input  req, len, abort, seq_out,
    output step, grant, busy, done, hit_cnt, aborted
  );
endinterface

// File: rtl/fsm_step_arbiter.sv
// Round-robin owner of a shared 3-state sequencer: drives its step input for a
// requested number of cycles and reports how many of them saw the output high.
module fsm_step_arbiter #(
  parameter int NREQ  = 4,
  parameter int CNT_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  fsm_step_arbiter_if.slave bus
);
  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]   rem_q, rem_d;
  logic [CNT_W-1:0]   hit_q, hit_d;
  logic               step_q, step_d;
  logic [NREQ-1:0]    grant_q, grant_d;
  logic               busy_q, busy_d;
  logic [NREQ-1:0]    done_q, done_d;
  logic [CNT_W-1:0]   hit_cnt_q, hit_cnt_d;
  logic               aborted_q, aborted_d;

  logic               win_found;
  logic [PTR_W-1:0]   win_idx;
  logic [NREQ-1:0]    win_onehot;
  logic [CNT_W-1:0]   win_len;
  logic [CNT_W-1:0]   hit_inc;

  // Search starts just past the last winner, so the previous owner ranks last.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!win_found && bus.req[(int'(ptr_q) + k) % NREQ]) begin
        win_found = 1'b1;
        win_idx   = PTR_W'((int'(ptr_q) + k) % NREQ);
      end
    end
  end

  assign win_onehot = {{(NREQ-1){1'b0}}, 1'b1} << win_idx;
  assign win_len    = bus.len[win_idx*CNT_W +: CNT_W];
  assign hit_inc    = hit_q + CNT_W'(bus.seq_out);

  // Outputs are computed for the state being entered, so they line up with it.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path can infer a latch.
    state_d   = state_q;
    ptr_d     = ptr_q;
    rem_d     = rem_q;
    hit_d     = hit_q;
    step_d    = 1'b0;
    grant_d   = grant_q;
    busy_d    = busy_q;
    done_d    = '0;
    hit_cnt_d = hit_cnt_q;
    aborted_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (win_found) begin
          grant_d = win_onehot;
          busy_d  = 1'b1;
          ptr_d   = win_idx;
          rem_d   = win_len;
          hit_d   = '0;
          if (win_len == '0) begin
            state_d   = DONE;
            done_d    = win_onehot;
            hit_cnt_d = '0;
          end else begin
            state_d = RUN;
            step_d  = 1'b1;
          end
        end
      end

      RUN: begin
        rem_d = rem_q - CNT_W'(1);
        hit_d = hit_inc;
        // A last step that coincides with abort is a normal completion.
        if (rem_q == CNT_W'(1) || bus.abort) begin
          state_d   = DONE;
          done_d    = grant_q;
          hit_cnt_d = hit_inc;
          aborted_d = (rem_q != CNT_W'(1));
        end else begin
          step_d = 1'b1;
        end
      end

      DONE: begin
        state_d = IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
      end

      default: begin
        state_d   = IDLE;
        grant_d   = '0;
        busy_d    = 1'b0;
        hit_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= PTR_W'(NREQ - 1);
      rem_q     <= '0;
      hit_q     <= '0;
      step_q    <= 1'b0;
      grant_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= '0;
      hit_cnt_q <= '0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      rem_q     <= rem_d;
      hit_q     <= hit_d;
      step_q    <= step_d;
      grant_q   <= grant_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      hit_cnt_q <= hit_cnt_d;
      aborted_q <= aborted_d;
    end
  end

  assign bus.step    = step_q;
  assign bus.grant   = grant_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.hit_cnt = hit_cnt_q;
  assign bus.aborted = aborted_q;
endmodule

// File: tb/tb_fsm_step_arbiter.sv
// Directed bench for fsm_step_arbiter with a behavioural model of the shared
// A->B->C sequencer feeding seq_out.
module tb_fsm_step_arbiter;
  localparam int NREQ  = 4;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic seq_clr = 1'b0;
  logic [1:0] seq_state;

  int checks = 0;
  int passed = 0;
  int failed = 0;

  fsm_step_arbiter_if #(.NREQ(NREQ), .CNT_W(CNT_W)) bus ();

  fsm_step_arbiter #(.NREQ(NREQ), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Shared sequencer: A=0, B=1, C=2; advances on step, output high in C.
  always @(posedge clk) begin
    if (seq_clr) seq_state <= 2'd0;
    else if (bus.step) seq_state <= (seq_state == 2'd2) ? 2'd0 : seq_state + 2'd1;
  end
  assign bus.seq_out = (seq_state == 2'd2);

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick;
    tick;
    rst = 1'b0;
  endtask

  task automatic clear_seq;
    seq_clr = 1'b1;
    tick;
    seq_clr = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NREQ-1:0] exp_order [5];
    exp_order[0] = 4'b0001;
    exp_order[1] = 4'b0010;
    exp_order[2] = 4'b0100;
    exp_order[3] = 4'b1000;
    exp_order[4] = 4'b0001;

    bus.req   = '0;
    bus.len   = '0;
    bus.abort = 1'b0;

    // Reset values
    seq_clr = 1'b1;
    rst = 1'b1;
    tick;
    tick;
    seq_clr = 1'b0;
    check("rst_step", bus.step, 0);
    check("rst_grant", bus.grant, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_hit_cnt", bus.hit_cnt, 0);
    check("rst_aborted", bus.aborted, 0);
    rst = 1'b0;

    // Run 1: requester 0, len 5, sequencer from A -> A,B,C,A,B -> hit 1
    bus.req = 4'b0001;
    bus.len[0 +: CNT_W] = 4'd5;
    tick;
    check("r1_grant", bus.grant, 4'b0001);
    check("r1_busy", bus.busy, 1);
    check("r1_step1", bus.step, 1);
    bus.req = '0;
    bus.len[0 +: CNT_W] = 4'd9;  // ignored: len was captured at grant
    for (int c = 2; c <= 5; c++) begin
      tick;
      check("r1_step", bus.step, 1);
      check("r1_no_done", bus.done, 0);
    end
    tick;
    check("r1_step_low", bus.step, 0);
    check("r1_done", bus.done, 4'b0001);
    check("r1_hit_cnt", bus.hit_cnt, 1);
    check("r1_aborted", bus.aborted, 0);
    check("r1_grant_held", bus.grant, 4'b0001);
    tick;
    check("r1_release_grant", bus.grant, 0);
    check("r1_release_busy", bus.busy, 0);
    check("r1_release_done", bus.done, 0);

    // Run 2: requester 0 again, len 3, sequencer continues (C,A,B) -> hit 1
    bus.req = 4'b0001;
    bus.len[0 +: CNT_W] = 4'd3;
    tick;
    check("r2_grant", bus.grant, 4'b0001);
    bus.req = '0;
    tick;
    check("r2_step2", bus.step, 1);
    tick;
    check("r2_step3", bus.step, 1);
    tick;
    check("r2_done", bus.done, 4'b0001);
    check("r2_hit_cnt", bus.hit_cnt, 1);
    tick;

    // Round robin: all request, len 1, from fresh pointer
    do_reset;
    bus.req = 4'b1111;
    bus.len = {4'd1, 4'd1, 4'd1, 4'd1};
    for (int i = 0; i < 5; i++) begin
      tick;
      check("rr_grant", bus.grant, exp_order[i]);
      check("rr_step", bus.step, 1);
      tick;
      check("rr_done", bus.done, exp_order[i]);
      check("rr_done_grant", bus.grant, exp_order[i]);
      tick;
      check("rr_idle_grant", bus.grant, 0);
    end
    bus.req = '0;
    tick;

    // Zero length: straight to DONE
    bus.req = 4'b0100;
    bus.len = '0;
    tick;
    check("z_grant", bus.grant, 4'b0100);
    check("z_done", bus.done, 4'b0100);
    check("z_step", bus.step, 0);
    check("z_hit_cnt", bus.hit_cnt, 0);
    check("z_busy", bus.busy, 1);
    bus.req = '0;
    tick;
    check("z_release", bus.grant, 0);
    check("z_step_after", bus.step, 0);

    // Abort on 4th step of a len 15 run, sequencer from A -> A,B,C,A -> hit 1
    clear_seq;
    bus.req = 4'b0010;
    bus.len[1*CNT_W +: CNT_W] = 4'd15;
    tick;
    check("ab_grant", bus.grant, 4'b0010);
    check("ab_step1", bus.step, 1);
    bus.req = '0;
    tick;
    check("ab_step2", bus.step, 1);
    tick;
    check("ab_step3", bus.step, 1);
    tick;
    check("ab_step4", bus.step, 1);
    bus.abort = 1'b1;
    tick;
    bus.abort = 1'b0;
    check("ab_step_low", bus.step, 0);
    check("ab_done", bus.done, 4'b0010);
    check("ab_aborted", bus.aborted, 1);
    check("ab_hit_cnt", bus.hit_cnt, 1);
    tick;
    check("ab_release", bus.grant, 0);

    // Abort in IDLE has no effect
    bus.abort = 1'b1;
    tick;
    bus.abort = 1'b0;
    check("ab_idle_busy", bus.busy, 0);
    check("ab_idle_done", bus.done, 0);

    // Abort on the last step: normal completion wins
    bus.req = 4'b0001;
    bus.len[0 +: CNT_W] = 4'd2;
    tick;
    bus.req = '0;
    tick;
    check("abl_step2", bus.step, 1);
    bus.abort = 1'b1;
    tick;
    bus.abort = 1'b0;
    check("abl_done", bus.done, 4'b0001);
    check("abl_aborted", bus.aborted, 0);
    tick;

    // Reset mid-run on the 2nd step of a len 6 run on requester 2
    bus.req = 4'b0100;
    bus.len[2*CNT_W +: CNT_W] = 4'd6;
    tick;
    check("mr_grant", bus.grant, 4'b0100);
    bus.req = '0;
    tick;
    check("mr_step2", bus.step, 1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("mr_step", bus.step, 0);
    check("mr_grant_clr", bus.grant, 0);
    check("mr_done", bus.done, 0);
    check("mr_busy", bus.busy, 0);
    bus.req = 4'b1010;
    bus.len[1*CNT_W +: CNT_W] = 4'd1;
    bus.len[3*CNT_W +: CNT_W] = 4'd1;
    tick;
    check("mr_ptr_reset_grant", bus.grant, 4'b0010);
    bus.req = '0;
    tick;
    tick;

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
